mux_8_1_rr: RTL and testbench
=============================

# mux_8_1_rr

Round-robin 8-to-1 collector with registered output and valid/ready handshake. It is the inverse of the 1-to-8 demultiplexer: eight independent lanes compete for one output, and each accepted word is tagged with its 3-bit source index `s` so a downstream `demux_1_8` can route it back out. It sits where eight per-channel producers share a single serial path.

## Interface
Parameters:
- `W`, default 1: data width of each lane and of `y`.

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst_n`, input, 1: reset, synchronous and active-low.
- `i0`..`i7`, input, W each: lane data.
- `v`, input, 8: per-lane valid; `v[k]` qualifies `ik`.
- `rdy`, output, 8: per-lane accept strobe. At most one bit is set, and it is combinational. `ik` is consumed on the edge where `v[k] && rdy[k]`.
- `y`, output, W: registered output data.
- `s`, output, 3: registered source index of `y`.
- `y_valid`, output, 1: `y`/`s` hold a word.
- `y_ready`, input, 1: downstream accepts; a transfer occurs on the edge where `y_valid && y_ready`.
- `p`, output, 1: parity bit; present only with `MUX_8_1_PARITY_EN` (see Configuration).

## Operation
- **State:**
  - 3-bit pointer `ptr`: the highest-priority lane.
  - Output register `{y, s, y_valid}`.
- **Load enable:** `ld_ok = !y_valid || y_ready`.
- **Arbitration (combinational):**
  - The winner is the first lane `k` with `v[k]=1`, scanning `ptr, ptr+1, ... ptr+7` (mod 8).
  - `rdy[k] = ld_ok && v[k] && (k == winner)`.
  - All `rdy` bits are 0 when `v == 0` or `!ld_ok`.
- **On an edge with `ld_ok`:**
  - If any `v` is set: `y <= i<winner>`, `s <= winner`, `y_valid <= 1`, `ptr <= winner+1` (mod 8, so 7 wraps to 0).
  - If no `v` is set: `y_valid <= 0`; `y`, `s` and `ptr` hold.
- **On an edge with `!ld_ok`:** all state holds; `y` and `s` stay stable while `y_valid && !y_ready`.
- **Fairness:** with all 8 lanes continuously valid and `y_ready=1`, grants follow the order 0,1,...,7,0. Any requesting lane is served within 8 loads.
- **Combinational paths:** `rdy` depends combinationally on `v`, `ptr`, `y_valid` and `y_ready`. Upstream `v` must not depend on `rdy`, or a combinational loop forms.

## Timing
- **Reset** (edge with `rst_n=0`, synchronous): `ptr=0`, `y=0`, `s=3'b000`, `y_valid=0`, `p=0`. `rdy=0` while `y_valid=0` and `v=0`.
- **Reset mid-operation:** a held, unaccepted word is discarded. After reset, the first grant goes to the lowest set lane starting from lane 0.
- **Latency:** `v[k]` high at edge N-1 gives `rdy[k]` during cycle N (if `k` wins), then `y=ik`, `s=k`, `y_valid=1` after edge N.
- **Throughput:** one word per cycle with `y_ready` held high; no bubbles while any `v` is set.
- **Simultaneous events:** on an edge where the output is consumed and a new winner loads, the new word replaces the old one in the same edge with no idle cycle.
- **Backpressure:** `y_ready` deasserted for any number of cycles leaves `y`, `s` and `ptr` frozen, and no lane is consumed.

## Configuration
- `MUX_8_1_PARITY_EN` defined:
  - Adds output `p`, registered alongside `y`: `p <= ^{s, i<winner>}` (even parity over tag and data).
  - `p` is 0 at reset and holds with `y`.
- `MUX_8_1_PARITY_EN` undefined: port `p` and its logic are absent. All other behaviour is identical.

## Test plan
- **Reset:** `rst_n=0` for 2 cycles with `v=8'hFF` → `y_valid=0`, `s=0`, `y=0`, `rdy=0` during reset. First cycle after release: `rdy=8'h01`.
- **Full load:** `W=1`, all `ik=1`, `v=8'hFF`, `y_ready=1` for 10 cycles → `s` sequence 0,1,2,3,4,5,6,7,0,1 with `y_valid` high continuously.
- **Sparse lanes:** `v=8'b1000_0100` held, `y_ready=1` → `s` alternates 2,7,2,7 (exercises the 7→0 wrap). `rdy` alternates `8'h04`, `8'h80`.
- **Backpressure:** `y_valid=1`, `s=3` held with `y_ready=0` for 5 cycles while `v=8'hFF` → `y`, `s` stable and `rdy=0`. Raise `y_ready` → next `s=4` one cycle later.
- **Drain:** `v` drops to 0 with `y_ready=1` → `y_valid=0` after one edge; `y` and `s` keep their last values.
- **Parity** (`MUX_8_1_PARITY_EN` defined): lane 5 only, `i5=1` → `s=3'b101`, `y=1`, `p=1`. Lane 3, `i3=0` → `p=0`.

Source files
------------

// File: rtl/mux_8_1_rr.sv
// ============================================================================
// mux_8_1_rr: round-robin 8:1 collector, tagged registered output (rev 1.0)
// Optional even-parity output p: define MUX_8_1_PARITY_EN
// ============================================================================
`default_nettype none

module mux_8_1_rr #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] i0,
  input  logic [W-1:0] i1,
  input  logic [W-1:0] i2,
  input  logic [W-1:0] i3,
  input  logic [W-1:0] i4,
  input  logic [W-1:0] i5,
  input  logic [W-1:0] i6,
  input  logic [W-1:0] i7,
  input  logic [7:0]   v,
  output logic [7:0]   rdy,
  output logic [W-1:0] y,
  output logic [2:0]   s,
  output logic         y_valid,
`ifdef MUX_8_1_PARITY_EN
  output logic         p,
`endif
  input  logic         y_ready
);

  logic [W-1:0] lane_w [8];
  logic [15:0]  vv_w;
  logic [7:0]   rot_w;
  logic [2:0]   off_w;
  logic [2:0]   win_w;
  logic         any_w;
  logic         ld_ok_w;
  logic         load_w;

  logic [2:0]   ptr_q,   ptr_d;
  logic [W-1:0] y_q,     y_d;
  logic [2:0]   s_q,     s_d;
  logic         valid_q, valid_d;
  logic         p_q,     p_d;

  assign lane_w[0] = i0;
  assign lane_w[1] = i1;
  assign lane_w[2] = i2;
  assign lane_w[3] = i3;
  assign lane_w[4] = i4;
  assign lane_w[5] = i5;
  assign lane_w[6] = i6;
  assign lane_w[7] = i7;

  // Rotate requests so bit 0 is the current priority lane; lowest set bit wins.
  assign vv_w  = {v, v} >> ptr_q;
  assign rot_w = vv_w[7:0];

  always_comb begin
    off_w = 3'd0;
    for (int j = 7; j >= 0; j--) begin
      if (rot_w[j]) off_w = 3'(j);
    end
  end

  assign win_w   = ptr_q + off_w;
  assign any_w   = |v;
  assign ld_ok_w = !valid_q || y_ready;
  assign load_w  = ld_ok_w && any_w;

  // Held low in reset so no lane believes it was consumed on a reset edge.
  assign rdy = (rst_n && load_w) ? (8'd1 << win_w) : 8'd0;

  always_comb begin
    ptr_d   = ptr_q;
    y_d     = y_q;
    s_d     = s_q;
    valid_d = valid_q;
    p_d     = p_q;
    if (ld_ok_w) begin
      if (any_w) begin
        y_d     = lane_w[win_w];
        s_d     = win_w;
        valid_d = 1'b1;
        ptr_d   = win_w + 3'd1;
        p_d     = ^{win_w, lane_w[win_w]};
      end else begin
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q   <= 3'd0;
      y_q     <= '0;
      s_q     <= 3'd0;
      valid_q <= 1'b0;
      p_q     <= 1'b0;
    end else begin
      ptr_q   <= ptr_d;
      y_q     <= y_d;
      s_q     <= s_d;
      valid_q <= valid_d;
      p_q     <= p_d;
    end
  end

  assign y       = y_q;
  assign s       = s_q;
  assign y_valid = valid_q;
`ifdef MUX_8_1_PARITY_EN
  assign p       = p_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mux_8_1_rr.sv
// ============================================================================
// tb_mux_8_1_rr: randomized + directed bench for mux_8_1_rr against a queue-free
// behavioural arbiter model (rev 1.0)
// ============================================================================
`default_nettype none

module tb_mux_8_1_rr;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] in [8];
  logic [7:0]   v;
  logic [7:0]   rdy;
  logic [W-1:0] y;
  logic [2:0]   s;
  logic         y_valid;
  logic         y_ready;
  logic         p;

  int tests = 0;
  int fails = 0;

  // Model state
  bit           live = 0;
  int           mptr;
  logic [W-1:0] my;
  int           ms;
  bit           mv;
  bit           mp;

  always #5 clk = ~clk;

  mux_8_1_rr #(.W(W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .i0      (in[0]),
    .i1      (in[1]),
    .i2      (in[2]),
    .i3      (in[3]),
    .i4      (in[4]),
    .i5      (in[5]),
    .i6      (in[6]),
    .i7      (in[7]),
    .v       (v),
    .rdy     (rdy),
    .y       (y),
    .s       (s),
    .y_valid (y_valid),
`ifdef MUX_8_1_PARITY_EN
    .p       (p),
`endif
    .y_ready (y_ready)
  );

`ifndef MUX_8_1_PARITY_EN
  assign p = 1'b0;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // First requesting lane scanning ptr, ptr+1, ... mod 8; -1 if none.
  function automatic int mwin();
    for (int i = 0; i < 8; i++) begin
      if (v[(mptr + i) % 8]) return (mptr + i) % 8;
    end
    return -1;
  endfunction

  function automatic logic [7:0] mrdy();
    int w;
    if (!rst_n) return 8'h00;
    if (mv && !y_ready) return 8'h00;
    w = mwin();
    if (w < 0) return 8'h00;
    return 8'(1 << w);
  endfunction

  function automatic bit parity_of(input int tag, input logic [W-1:0] d);
    int ones = 0;
    for (int b = 0; b < 3; b++) ones += (tag >> b) & 1;
    for (int b = 0; b < W; b++) ones += int'(d[b]);
    return bit'(ones % 2);
  endfunction

  // One cycle: compare on the falling edge, advance the model on the rising edge.
  task automatic step();
    int w;
    @(negedge clk);
    if (live) begin
      chk("rdy",     {24'd0, rdy},     {24'd0, mrdy()});
      chk("y_valid", {31'd0, y_valid}, {31'd0, mv});
      chk("s",       {29'd0, s},       ms);
      chk("y",       32'(y),           32'(my));
`ifdef MUX_8_1_PARITY_EN
      chk("p",       {31'd0, p},       {31'd0, mp});
`endif
    end
    @(posedge clk);
    if (!rst_n) begin
      mptr = 0; my = '0; ms = 0; mv = 0; mp = 0; live = 1;
    end else if (live && (!mv || y_ready)) begin
      w = mwin();
      if (w >= 0) begin
        my = in[w]; ms = w; mv = 1; mp = parity_of(w, in[w]);
        mptr = (w + 1) % 8;
      end else begin
        mv = 0;
      end
    end
    #1;
  endtask

  initial begin
    rst_n = 1'b0; v = 8'hFF; y_ready = 1'b1;
    for (int k = 0; k < 8; k++) in[k] = W'(1);

    // Reset with all lanes requesting
    step(); step();
    chk("rst_y_valid", {31'd0, y_valid}, 0);
    chk("rst_s",       {29'd0, s},       0);
    chk("rst_y",       32'(y),           0);
    chk("rst_rdy",     {24'd0, rdy},     0);
    rst_n = 1'b1; #1;
    chk("first_rdy",   {24'd0, rdy},     32'h01);

    // Full load: grants 0..7,0,1
    for (int i = 0; i < 10; i++) begin
      step();
      chk("full_s",     {29'd0, s},       i % 8);
      chk("full_valid", {31'd0, y_valid}, 1);
    end

    // Sparse lanes 2 and 7 alternate across the wrap
    v = 8'b1000_0100; #1;
    for (int i = 0; i < 4; i++) begin
      chk("sparse_rdy", {24'd0, rdy}, (i % 2 == 0) ? 32'h04 : 32'h80);
      step();
      chk("sparse_s",   {29'd0, s},   (i % 2 == 0) ? 2 : 7);
    end

    // Backpressure: hold s=3 while everyone requests
    for (int k = 0; k < 8; k++) in[k] = W'(k + 1);
    v = 8'h08; step();
    chk("bp_load_s", {29'd0, s}, 3);
    v = 8'hFF; y_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1 chk("bp_rdy", {24'd0, rdy}, 0);
      step();
      chk("bp_s", {29'd0, s},  3);
      chk("bp_y", 32'(y),      4);
    end
    y_ready = 1'b1; step();
    chk("bp_release_s", {29'd0, s}, 4);

    // Drain
    v = 8'h00; step();
    chk("drain_valid", {31'd0, y_valid}, 0);
    chk("drain_s",     {29'd0, s},       4);
    chk("drain_y",     32'(y),           5);

`ifdef MUX_8_1_PARITY_EN
    in[5] = W'(1); v = 8'h20; step();
    chk("par5_s", {29'd0, s}, 5);
    chk("par5_y", 32'(y),     1);
    chk("par5_p", {31'd0, p}, 1);
    in[3] = W'(0); v = 8'h08; step();
    chk("par3_p", {31'd0, p}, 0);
`endif

    // Reset while a word is held and stalled
    v = 8'h40; y_ready = 1'b0; step();
    rst_n = 1'b0; step();
    chk("midrst_valid", {31'd0, y_valid}, 0);
    rst_n = 1'b1; v = 8'hFF; #1;
    chk("midrst_rdy", {24'd0, rdy}, 32'h01);

    // Randomized traffic with occasional reset
    for (int i = 0; i < 600; i++) begin
      for (int k = 0; k < 8; k++) in[k] = W'($urandom);
      case ($urandom_range(0, 3))
        0:       v = 8'h00;
        1:       v = 8'(1 << $urandom_range(0, 7));
        default: v = 8'($urandom);
      endcase
      y_ready = ($urandom_range(0, 9) < 7);
      rst_n   = ($urandom_range(0, 99) != 0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
